// File: rtl/midi_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : midi_tx_if
// Brief    : 8-bit Wishbone slave bus bundle for the MIDI transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface midi_tx_if;
    logic [7:0] wb_addr_i;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_stb_i;
    logic       wb_we_i;
    logic       wb_ack_o;

    modport master (
        output wb_addr_i, wb_dat_i, wb_stb_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_addr_i, wb_dat_i, wb_stb_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/midi_tx.sv
`default_nettype none
// ============================================================================
// Module   : midi_tx
// Brief    : Wishbone-fed MIDI/UART 8N1 transmitter with a small TX FIFO.
//            Optional running-status compression: MIDI_TX_RUNNING_STATUS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module midi_tx #(
    parameter int         CLKS_PER_BIT    = 8,
    parameter int         FIFO_DEPTH_LOG2 = 2,
    parameter logic [7:0] BASE_ADDR       = 8'h10
) (
    input  logic     wb_clk_i,
    input  logic     wb_rst_i,
    midi_tx_if.slave bus,
    output logic     midi_out,
    output logic     tx_busy
);
    localparam int              c_DEPTH       = 1 << FIFO_DEPTH_LOG2;
    localparam int              c_CW          = FIFO_DEPTH_LOG2 + 1;
    localparam logic [c_CW-1:0] c_FULL_CNT    = c_CW'(c_DEPTH);
    localparam logic [15:0]     c_BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic                       w_sel, w_wr, w_push, w_clr_ovf, w_push_ok;
    logic                       w_full, w_empty, w_pop, w_discard;
    logic [7:0]                 w_head, w_rdata;
    logic [7:0]                 r_mem [c_DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0]            r_count;
    logic                       r_ovf;

    state_t      r_state, w_state_nx;
    logic [7:0]  r_shift, w_shift_nx;
    logic [15:0] r_baud, w_baud_nx;
    logic [2:0]  r_bit, w_bit_nx;
    logic        r_out, w_out_nx;

    // ------------------------------------------------------------ bus decode
    assign w_sel        = (bus.wb_addr_i[7:2] == BASE_ADDR[7:2]);
    assign w_wr         = bus.wb_stb_i & bus.wb_we_i & w_sel;
    assign w_push       = w_wr & (bus.wb_addr_i[1:0] == 2'd0);
    assign w_clr_ovf    = w_wr & (bus.wb_addr_i[1:0] == 2'd1) & bus.wb_dat_i[3];
    assign bus.wb_ack_o = bus.wb_stb_i & w_sel;

    always_comb begin
        w_rdata = 8'h00;
        if (w_sel && (bus.wb_addr_i[1:0] == 2'd1))
            w_rdata = {4'(r_count), r_ovf, w_full, w_empty, tx_busy};
    end
    assign bus.wb_dat_o = w_rdata;

    // ------------------------------------------------------------------ FIFO
    assign w_full    = (r_count == c_FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_push_ok = w_push & ~w_full;
    assign w_head    = r_mem[r_rd_ptr];

    always_ff @(posedge wb_clk_i) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= bus.wb_dat_i;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Overflow is judged on the pre-edge full flag, so a same-edge pop
            // does not rescue the byte; a set beats a same-edge clear.
            if (w_push && w_full)
                r_ovf <= 1'b1;
            else if (w_clr_ovf)
                r_ovf <= 1'b0;
        end
    end

    // -------------------------------------------------------- running status
`ifdef MIDI_TX_RUNNING_STATUS_EN
    logic [7:0] r_last;
    logic       r_last_vld;
    logic       w_is_chan, w_is_sys;

    assign w_is_chan = (w_head[7:4] >= 4'h8) && (w_head[7:4] <= 4'hE);
    assign w_is_sys  = (w_head[7:3] == 5'b11110);
    assign w_discard = w_is_chan && r_last_vld && (w_head == r_last);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_last     <= 8'h00;
            r_last_vld <= 1'b0;
        end else if (w_pop) begin
            if (w_is_chan && !w_discard) begin
                r_last     <= w_head;
                r_last_vld <= 1'b1;
            end else if (w_is_sys) begin
                r_last_vld <= 1'b0;
            end
        end
    end
`else
    assign w_discard = 1'b0;
`endif

    // -------------------------------------------------------------- TX FSM
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_shift <= 8'h00;
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_out   <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_shift <= w_shift_nx;
            r_baud  <= w_baud_nx;
            r_bit   <= w_bit_nx;
            r_out   <= w_out_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_baud_nx  = r_baud;
        w_bit_nx   = r_bit;
        w_out_nx   = r_out;
        w_pop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (!w_discard) begin
                        w_state_nx = S_START;
                        w_shift_nx = w_head;
                        w_baud_nx  = c_BAUD_RELOAD;
                        w_out_nx   = 1'b0;
                    end
                end
            end
            S_START: begin
                if (r_baud == 16'd0) begin
                    w_state_nx = S_DATA;
                    w_baud_nx  = c_BAUD_RELOAD;
                    w_bit_nx   = 3'd0;
                    w_out_nx   = r_shift[0];
                    w_shift_nx = {1'b0, r_shift[7:1]};
                end else begin
                    w_baud_nx = r_baud - 16'd1;
                end
            end
            S_DATA: begin
                if (r_baud == 16'd0) begin
                    w_baud_nx = c_BAUD_RELOAD;
                    if (r_bit == 3'd7) begin
                        w_state_nx = S_STOP;
                        w_out_nx   = 1'b1;
                    end else begin
                        w_bit_nx   = r_bit + 3'd1;
                        w_out_nx   = r_shift[0];
                        w_shift_nx = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_baud_nx = r_baud - 16'd1;
                end
            end
            S_STOP: begin
                if (r_baud == 16'd0) begin
                    w_state_nx = S_IDLE;
                    // Chain straight into the next start bit with no idle gap.
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        if (!w_discard) begin
                            w_state_nx = S_START;
                            w_shift_nx = w_head;
                            w_baud_nx  = c_BAUD_RELOAD;
                            w_out_nx   = 1'b0;
                        end
                    end
                end else begin
                    w_baud_nx = r_baud - 16'd1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign midi_out = r_out;
    assign tx_busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire
